// File: rtl/microwave_time_entry.sv
// Keypad MM:SS entry and load/enable sequencing for the BCD cook-timer counter chain.
// Optional feature macro: QUICK_START_EN (start from IDLE loads QUICK_SECS and runs).
module microwave_time_entry #(
    parameter int SEC_TENS_MAX = 5,
    parameter int QUICK_SECS   = 30
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       count_en,
    output logic       entering,
    output logic       err,
    output logic [2:0] digit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_LOAD,
        S_RUN
    } state_t;

    localparam logic [3:0]  SEC_TENS_LIM = SEC_TENS_MAX[3:0];
    localparam logic [15:0] QUICK_BCD    = {8'h00, 4'(QUICK_SECS / 10), 4'(QUICK_SECS % 10)};

    if (SEC_TENS_MAX < 0 || SEC_TENS_MAX > 9) begin : g_bad_sec_tens
        $error("SEC_TENS_MAX must be a single BCD digit");
    end
    if (QUICK_SECS < 0 || QUICK_SECS > 59) begin : g_bad_quick
        $error("QUICK_SECS must be in 0..59");
    end

    state_t      r_state, w_state_nxt;
    logic [15:0] r_buf, w_buf_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_err, w_err_nxt;
    logic        r_key_prev, r_start_prev;

    logic        w_key_edge, w_start_edge, w_digit_key;

    // An entry may start only if the seconds-tens digit is legal and the time is non-zero.
    function automatic logic entry_valid(input logic [15:0] b);
        return (b[7:4] <= SEC_TENS_LIM) && (b != 16'h0000);
    endfunction

    assign w_key_edge   = key_valid & ~r_key_prev;
    assign w_start_edge = start & ~r_start_prev;
    assign w_digit_key  = w_key_edge && (key_code <= 4'd9);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state      <= S_IDLE;
            r_buf        <= 16'h0000;
            r_cnt        <= 3'd0;
            r_err        <= 1'b0;
            r_key_prev   <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_err        <= w_err_nxt;
            r_key_prev   <= key_valid;
            r_start_prev <= start;
        end
    end

    // Priority: stop > timer_done > start edge > key edge.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (stop) begin
            w_state_nxt = S_IDLE;
            w_buf_nxt   = 16'h0000;
            w_cnt_nxt   = 3'd0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
`ifdef QUICK_START_EN
                        w_buf_nxt   = QUICK_BCD;
                        w_state_nxt = S_LOAD;
`else
                        w_err_nxt   = 1'b1;
`endif
                    end else if (w_digit_key) begin
                        w_buf_nxt   = {12'h000, key_code};
                        w_cnt_nxt   = 3'd1;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_start_edge) begin
                        if (entry_valid(r_buf)) begin
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (w_digit_key) begin
                        w_err_nxt = 1'b0;
                        if (r_cnt < 3'd4) begin
                            w_buf_nxt = {r_buf[11:0], key_code};
                            w_cnt_nxt = r_cnt + 3'd1;
                        end
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (timer_done) begin
                        w_state_nxt = S_IDLE;
                        w_buf_nxt   = 16'h0000;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign min_tens  = r_buf[15:12];
    assign min_ones  = r_buf[11:8];
    assign sec_tens  = r_buf[7:4];
    assign sec_ones  = r_buf[3:0];
    assign loadn     = (r_state != S_LOAD);
    assign count_en  = (r_state == S_RUN);
    assign entering  = (r_state == S_ENTRY);
    assign err       = r_err;
    assign digit_cnt = r_cnt;

endmodule

// File: tb/tb_microwave_time_entry.sv
// Bench for microwave_time_entry: directed scenarios plus random stimulus vs a decimal-arithmetic model.
module tb_microwave_time_entry;

    localparam int SEC_TENS_MAX = 5;
    localparam int QUICK_SECS   = 30;

    logic       clk = 1'b0;
    logic       clrn, key_valid, start, stop, timer_done;
    logic [3:0] key_code;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       loadn, count_en, entering, err;
    logic [2:0] digit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model: time held as a decimal number MMSS, mode 0=idle 1=entry 2=load 3=running.
    int m_mode, m_time, m_cnt;
    bit m_err, m_kprev, m_sprev;

    microwave_time_entry #(
        .SEC_TENS_MAX(SEC_TENS_MAX),
        .QUICK_SECS  (QUICK_SECS)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .key_valid (key_valid),
        .key_code  (key_code),
        .start     (start),
        .stop      (stop),
        .timer_done(timer_done),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .loadn     (loadn),
        .count_en  (count_en),
        .entering  (entering),
        .err       (err),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] dut_buf();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] to_bcd(input int t);
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    task automatic model_update();
        bit kedge, sedge, dkey;
        if (!clrn) begin
            m_mode = 0; m_time = 0; m_cnt = 0; m_err = 0; m_kprev = 0; m_sprev = 0;
            return;
        end
        kedge = key_valid && !m_kprev;
        sedge = start && !m_sprev;
        dkey  = kedge && (key_code < 10);
        if (stop) begin
            m_mode = 0; m_time = 0; m_cnt = 0; m_err = 0;
        end else if (m_mode == 3) begin
            if (timer_done) begin
                m_mode = 0; m_time = 0; m_cnt = 0;
            end
        end else if (m_mode == 2) begin
            m_mode = 3;
        end else if (sedge) begin
            if (m_mode == 0) begin
`ifdef QUICK_START_EN
                m_time = QUICK_SECS;
                m_mode = 2;
`else
                m_err = 1;
`endif
            end else if (m_time == 0 || ((m_time / 10) % 10) > SEC_TENS_MAX) begin
                m_err = 1;
            end else begin
                m_mode = 2;
            end
        end else if (dkey) begin
            m_err = 0;
            if (m_mode == 0) begin
                m_time = int'(key_code); m_cnt = 1; m_mode = 1;
            end else if (m_cnt < 4) begin
                m_time = m_time * 10 + int'(key_code); m_cnt++;
            end
        end
        m_kprev = key_valid;
        m_sprev = start;
    endtask

    task automatic compare_all();
        check("buf",       32'(dut_buf()),   32'(to_bcd(m_time)));
        check("loadn",     32'(loadn),       32'(m_mode != 2));
        check("count_en",  32'(count_en),    32'(m_mode == 3));
        check("entering",  32'(entering),    32'(m_mode == 1));
        check("err",       32'(err),         32'(m_err));
        check("digit_cnt", 32'(digit_cnt),   32'(m_cnt));
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic st,
                        input logic sp, input logic td, input logic rn);
        @(negedge clk);
        key_valid = kv; key_code = kc; start = st; stop = sp; timer_done = td; clrn = rn;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic idle_cyc();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cyc();
    endtask

    task automatic do_stop();
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cyc();
    endtask

    initial begin
        clrn = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        start = 1'b0; stop = 1'b0; timer_done = 1'b0;
        m_mode = 0; m_time = 0; m_cnt = 0; m_err = 0; m_kprev = 0; m_sprev = 0;

        // Reset with every input active
        step(1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_buf", 32'(dut_buf()), 32'h0000);
        check("rst_loadn", 32'(loadn), 32'd1);
        check("rst_cnt", 32'(digit_cnt), 32'd0);
        idle_cyc();

        // Entry 1,3,0 then start, then terminal count
        press(4'd1); press(4'd3); press(4'd0);
        check("e130_buf", 32'(dut_buf()), 32'h0130);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("e130_loadn", 32'(loadn), 32'd0);
        check("e130_en_load", 32'(count_en), 32'd0);
        idle_cyc();
        check("e130_loadn_hi", 32'(loadn), 32'd1);
        check("e130_en_run", 32'(count_en), 32'd1);
        check("e130_hold", 32'(dut_buf()), 32'h0130);
        press(4'd9);
        check("run_key_ign", 32'(dut_buf()), 32'h0130);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("done_en", 32'(count_en), 32'd0);
        check("done_buf", 32'(dut_buf()), 32'h0000);

        // Overflow, held key, ignored code
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        for (int i = 0; i < 5; i++) step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        press(4'd11);
        check("ovf_buf", 32'(dut_buf()), 32'h1234);
        check("ovf_cnt", 32'(digit_cnt), 32'd4);
        do_stop();

        // Invalid seconds-tens on start, then recovery key
        press(4'd1); press(4'd7); press(4'd5);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("inv_err", 32'(err), 32'd1);
        check("inv_loadn", 32'(loadn), 32'd1);
        idle_cyc();
        check("inv_entering", 32'(entering), 32'd1);
        check("inv_buf", 32'(dut_buf()), 32'h0175);
        press(4'd0);
        check("inv_clr_err", 32'(err), 32'd0);
        check("inv_buf2", 32'(dut_buf()), 32'h1750);
        do_stop();

        // Stop beats start; stop in RUNNING; reset during LOAD
        press(4'd1);
        step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("pri_loadn", 32'(loadn), 32'd1);
        check("pri_buf", 32'(dut_buf()), 32'h0000);
        idle_cyc();
        press(4'd2);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cyc();
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stop_run_en", 32'(count_en), 32'd0);
        idle_cyc();
        press(4'd5);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_load_loadn", 32'(loadn), 32'd1);
        idle_cyc();

        // Start from IDLE
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef QUICK_START_EN
        check("idle_start_buf", 32'(dut_buf()), 32'h0030);
        check("idle_start_loadn", 32'(loadn), 32'd0);
        idle_cyc();
        check("idle_start_run", 32'(count_en), 32'd1);
`else
        check("idle_start_err", 32'(err), 32'd1);
        idle_cyc();
        check("idle_start_state", 32'(count_en | entering), 32'd0);
`endif
        do_stop();

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            logic kv, st, sp, td, rn;
            logic [3:0] kc;
            kv = ($urandom_range(0, 2) == 0);
            kc = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 30) == 0);
            td = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 200) != 0);
            step(kv, kc, st, sp, td, rn);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/microwave_time_entry.md
Name: microwave_time_entry

Overview:
Keypad time-entry front end for the microwave cook timer: the writer side of the BCD mod-10 counter chain. It collects decimal key presses into a 4-digit MM:SS BCD buffer and validates the entry on start. It then drives the counters' data buses with a one-cycle active-low load pulse, gates their enable while cooking, and returns to idle on the chain's terminal count.

Parameters:
SEC_TENS_MAX, 5, highest legal seconds-tens digit; start is rejected above it
QUICK_SECS, 30, quick-start time in seconds (0..59), used only with QUICK_START_EN

Ports:
clk  input  1  system clock, all logic on rising edge
clrn  input  1  synchronous active-low reset
key_valid  input  1  key strobe; action on rising edge only
key_code  input  4  digit 0..9 with key_valid; codes 10..15 ignored
start  input  1  start button; action on rising edge only
stop  input  1  stop/clear button, level-sampled
timer_done  input  1  terminal count of the whole counter chain (all digits zero)
min_tens  output  4  BCD data to minutes-tens counter
min_ones  output  4  BCD data to minutes-ones counter
sec_tens  output  4  BCD data to seconds-tens counter
sec_ones  output  4  BCD data to seconds-ones counter
loadn  output  1  active-low load strobe to all counters
count_en  output  1  enable to counter chain; high only in RUNNING
entering  output  1  high in ENTRY
err  output  1  high after a rejected start; cleared by next key, stop or reset
digit_cnt  output  3  digits entered, 0..4

Behaviour:
- Reset (clrn=0 at clock edge): state IDLE; all digits 0; loadn=1; count_en=0; entering=0; err=0; digit_cnt=0; edge-detect registers cleared. Reset wins over every input in every state, including mid-RUNNING.
- Edge detect: registered previous key_valid/start. Event = current high and previous low. Held inputs never repeat.
- Priority within a cycle: stop > timer_done > start edge > key edge.
- States: IDLE, ENTRY, LOAD, RUNNING.
- IDLE:
  - Key edge with code 0..9: buffer becomes 000d, digit_cnt=1, go to ENTRY.
  - Start edge: err=1, stay IDLE (without macro).
- ENTRY:
  - Key edge with digit: shift left (min_tens<-min_ones<-sec_tens<-sec_ones<-d), digit_cnt+1. Takes effect on the next edge.
  - At digit_cnt=4, further digits are ignored: buffer unchanged, no error.
  - Codes >9 are ignored in every state.
  - Any accepted key clears err.
- Start edge in ENTRY:
  - If sec_tens > SEC_TENS_MAX or buffer = 0000: err=1, stay ENTRY, buffer kept.
  - Otherwise go to LOAD.
- LOAD: exactly one cycle. loadn=0, digit outputs stable, count_en=0. Next state RUNNING.
- RUNNING:
  - count_en=1; key and start edges ignored; digit outputs hold the loaded value.
  - timer_done=1: go to IDLE, clear buffer and digit_cnt. count_en drops on the same edge.
- stop=1 in any state: go to IDLE, clear buffer, digit_cnt and err, count_en=0, loadn=1. A stop during LOAD aborts it; loadn returns high on that edge.
- Latency: start edge sampled at edge N gives LOAD (loadn=0) during cycle N..N+1 and count_en=1 from edge N+1.
- timer_done is ignored outside RUNNING.

Optional Feature:
QUICK_START_EN
- Defined: a start edge in IDLE loads the buffer with QUICK_SECS as BCD (30 -> 00:30) and goes to LOAD then RUNNING; err is not set.
- Not defined: a start edge in IDLE sets err=1 and the state stays IDLE.

Test Plan:
- Reset: clrn=0 for 2 cycles with all inputs active -> IDLE, all digits 0, loadn=1, count_en=0, err=0, digit_cnt=0.
- Entry then start: keys 1,3,0 then start -> buffer 01:30, one-cycle loadn=0, count_en=1 next cycle. Then timer_done=1 -> IDLE with buffer 0000.
- Overflow and hold: keys 1,2,3,4,5, plus key_valid held high 5 cycles -> buffer 12:34, digit_cnt=4, no repeats. Code 11 -> ignored.
- Invalid start: keys 1,7,5 then start -> err=1, ENTRY, buffer 01:75, loadn never low. Key 0 -> err=0, buffer 17:50.
- Priority: stop and start same cycle in ENTRY -> IDLE, no load. Stop during RUNNING -> count_en=0 next edge. clrn=0 during LOAD -> loadn=1 after edge.
- Macro: with QUICK_START_EN, start in IDLE -> buffer 00:30 then RUNNING. Without it -> err=1, IDLE.
